// File: rtl/zero_skip_dot_seq_pkg.sv
// Shared widths and FSM state codes for the zero-skip dot-product sequencer.
package zero_skip_dot_seq_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;
    localparam int CNT_W  = 8;

    typedef logic [1:0] state_t;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/zero_skip_dot_seq_sat.sv
// sat_acc: ACC_W-wide unsigned add of a zero-extended product, clamped to all-ones on carry-out.
module sat_acc
    import zero_skip_dot_seq_pkg::*;
#(
    parameter int ACC_W = 24
) (
    input  logic [ACC_W-1:0]  acc,
    input  logic [PROD_W-1:0] addend,
    output logic [ACC_W-1:0]  sum,
    output logic              overflow
);

    logic [ACC_W:0] wide;

    always_comb begin
        wide     = {1'b0, acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, addend};
        overflow = wide[ACC_W];
        sum      = overflow ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
    end

endmodule

// File: rtl/zero_skip_dot_seq.sv
// Dot-product sequencer: feeds operand pairs to an external zero-detect multiplier
// and accumulates the returned products with saturation.
module zero_skip_dot_seq
    import zero_skip_dot_seq_pkg::*;
#(
    parameter int ACC_W   = 24,
    parameter int MAX_LEN = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_a,
    input  logic [OP_W-1:0]   in_b,
    output logic              mul_valid_in,
    output logic [OP_W-1:0]   mul_a,
    output logic [OP_W-1:0]   mul_b,
    input  logic [PROD_W-1:0] mul_result,
    input  logic              mul_skipped,
    input  logic              mul_valid_out,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  dot,
    output logic [CNT_W-1:0]  skip_count,
    output logic              overflow,
    output state_t            state
);

    localparam logic [CNT_W-1:0] MAX_LEN_C = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    logic [CNT_W-1:0] len_q;
    logic [CNT_W-1:0] len_eff;
    logic [CNT_W-1:0] issued;
    logic [CNT_W-1:0] received;
    logic             handshake;
    logic             acc_en;
    logic [ACC_W-1:0] acc_sum;
    logic             acc_ovf;

    // A pair transfers on any cycle where in_valid and in_ready are both high;
    // in_ready does not depend on in_valid, and in_valid may drop at any time to stall.
    assign in_ready  = (state == ST_ISSUE) && (issued < len_q);
    assign handshake = in_valid && in_ready;
    assign len_eff   = (len > MAX_LEN_C) ? MAX_LEN_C : len;
    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);

    // Products arriving while idle or finished are stale (e.g. issued before a reset).
    assign acc_en = mul_valid_out && ((state == ST_ISSUE) || (state == ST_DRAIN));

    sat_acc #(
        .ACC_W(ACC_W)
    ) u_sat_acc (
        .acc      (dot),
        .addend   (mul_result),
        .sum      (acc_sum),
        .overflow (acc_ovf)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            len_q        <= '0;
            issued       <= '0;
            received     <= '0;
            mul_valid_in <= 1'b0;
            mul_a        <= '0;
            mul_b        <= '0;
            dot          <= '0;
            skip_count   <= '0;
            overflow     <= 1'b0;
        end else begin
            mul_valid_in <= handshake;
            if (handshake) begin
                mul_a  <= in_a;
                mul_b  <= in_b;
                issued <= issued + ONE;
            end
            if (acc_en) begin
                dot      <= acc_sum;
                overflow <= overflow | acc_ovf;
                received <= received + ONE;
                if (mul_skipped) begin
                    skip_count <= skip_count + ONE;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        len_q      <= len_eff;
                        issued     <= '0;
                        received   <= '0;
                        dot        <= '0;
                        skip_count <= '0;
                        overflow   <= 1'b0;
                        state      <= (len_eff == '0) ? ST_DONE : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (handshake && (issued + ONE == len_q)) begin
                        state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (acc_en && (received + ONE == len_q)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zero_skip_dot_seq.sv
// Bench for zero_skip_dot_seq with a behavioural zero-detect multiplier on the mul_* ports.
module tb_zero_skip_dot_seq;
    import zero_skip_dot_seq_pkg::*;

    localparam int ACC_W   = 16;
    localparam int MAX_LEN = 20;
    localparam int ACC_MAX = (1 << ACC_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [CNT_W-1:0]  len;
    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   in_a;
    logic [OP_W-1:0]   in_b;
    logic              mul_valid_in;
    logic [OP_W-1:0]   mul_a;
    logic [OP_W-1:0]   mul_b;
    logic [PROD_W-1:0] mul_result;
    logic              mul_skipped;
    logic              mul_valid_out;
    logic              busy;
    logic              done;
    logic [ACC_W-1:0]  dot;
    logic [CNT_W-1:0]  skip_count;
    logic              overflow;
    state_t            state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // One-cycle multiplier that reports a skip when either operand is zero.
    // It is deliberately not reset, so products in flight at reset still emerge.
    initial begin
        mul_valid_out = 1'b0;
        mul_result    = '0;
        mul_skipped   = 1'b0;
    end
    always @(posedge clk) begin
        mul_valid_out <= mul_valid_in;
        if (mul_valid_in) begin
            mul_skipped <= (mul_a == 0) || (mul_b == 0);
            mul_result  <= {8'd0, mul_a} * {8'd0, mul_b};
        end
    end

    zero_skip_dot_seq #(
        .ACC_W   (ACC_W),
        .MAX_LEN (MAX_LEN)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .len           (len),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_a          (in_a),
        .in_b          (in_b),
        .mul_valid_in  (mul_valid_in),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_result    (mul_result),
        .mul_skipped   (mul_skipped),
        .mul_valid_out (mul_valid_out),
        .busy          (busy),
        .done          (done),
        .dot           (dot),
        .skip_count    (skip_count),
        .overflow      (overflow),
        .state         (state)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [7:0] pa[256];
    logic [7:0] pb[256];

    typedef struct {
        int         len;
        int         mode;
        logic [7:0] a[4];
        logic [7:0] b[4];
        int         exp_dot;
        int         exp_skip;
        int         exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input int l, input int m,
                           input int a0, input int b0, input int a1, input int b1,
                           input int a2, input int b2, input int a3, input int b3,
                           input int ed, input int es, input int eo);
        vec_t v;
        v.len = l; v.mode = m;
        v.a[0] = 8'(a0); v.b[0] = 8'(b0);
        v.a[1] = 8'(a1); v.b[1] = 8'(b1);
        v.a[2] = 8'(a2); v.b[2] = 8'(b2);
        v.a[3] = 8'(a3); v.b[3] = 8'(b3);
        v.exp_dot = ed; v.exp_skip = es; v.exp_ovf = eo;
        vecs.push_back(v);
    endtask

    int r_done, r_dot, r_skip, r_ovf, r_pulses, r_lat;

    // mode 0: in_valid continuous, 1: every other cycle, 2: random gaps.
    // poke pulses start (len=1) mid-operation, which must be ignored.
    task automatic run_op(input int n_len, input int mode, input bit poke);
        int eff, idx, start_cyc, last_hs;
        bit poked;
        eff = (n_len > MAX_LEN) ? MAX_LEN : n_len;
        @(negedge clk);
        start = 1'b1; len = 8'(n_len); in_valid = 1'b0; start_cyc = cyc;
        @(negedge clk);
        idx = 0; last_hs = 0; poked = 1'b0;
        r_done = 0; r_pulses = 0; r_dot = 0; r_skip = 0; r_ovf = 0; r_lat = 0;
        for (int k = 0; k < 400; k++) begin
            start = 1'b0;
            if (idx < eff && (mode == 0 || (mode == 1 && k % 2 == 0) ||
                              (mode == 2 && $urandom_range(0, 3) != 0))) begin
                in_valid = 1'b1; in_a = pa[idx]; in_b = pb[idx];
            end else begin
                in_valid = 1'b0; in_a = 8'($urandom); in_b = 8'($urandom);
            end
            if (poke && !poked && idx == 1) begin
                start = 1'b1; len = 8'd1; poked = 1'b1;
            end
            if (mul_valid_in) r_pulses++;
            if (done) begin
                r_done = 1; r_dot = int'(dot); r_skip = int'(skip_count); r_ovf = int'(overflow);
                r_lat = (eff == 0) ? cyc - start_cyc : cyc - last_hs;
                break;
            end
            if (in_valid && in_ready) begin
                idx++; last_hs = cyc;
            end
            @(negedge clk);
        end
        in_valid = 1'b0; start = 1'b0;
    endtask

    task automatic check_op(input string tag, input int eff, input int ed, input int es, input int eo);
        check({tag, " done_seen"}, r_done, 1);
        if (r_done != 0) begin
            check({tag, " dot"}, r_dot, ed);
            check({tag, " skip_count"}, r_skip, es);
            check({tag, " overflow"}, r_ovf, eo);
            check({tag, " mul_pulses"}, r_pulses, eff);
            check({tag, " latency"}, r_lat, (eff == 0) ? 1 : 3);
            @(negedge clk);
            check({tag, " done_one_cycle"}, {31'd0, done}, 0);
            check({tag, " idle_after"}, {31'd0, busy}, 0);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, " in_ready"}, {31'd0, in_ready}, 0);
        check({tag, " mul_valid_in"}, {31'd0, mul_valid_in}, 0);
        check({tag, " busy"}, {31'd0, busy}, 0);
        check({tag, " done"}, {31'd0, done}, 0);
        check({tag, " overflow"}, {31'd0, overflow}, 0);
        check({tag, " dot"}, {16'd0, dot}, 0);
        check({tag, " skip_count"}, {24'd0, skip_count}, 0);
        check({tag, " mul_a"}, {24'd0, mul_a}, 0);
        check({tag, " mul_b"}, {24'd0, mul_b}, 0);
        check({tag, " state"}, {30'd0, state}, 0);
    endtask

    initial begin
        int n_len, eff, sum, skips, r, hs;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_a = '0; in_b = '0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst = 1'b0;

        add_vec(3, 0,   5,   3,   0,   7,  12, 10,   0, 0,   135, 1, 0);
        add_vec(0, 0,   0,   0,   0,   0,   0,  0,   0, 0,     0, 0, 0);
        add_vec(4, 1,   1, 200,   1, 200,   1, 200,  1, 200, 800, 0, 0);
        add_vec(2, 0, 255, 255, 255, 255,   0,  0,   0, 0, 65535, 0, 1);
        add_vec(1, 0,   2,   2,   0,   0,   0,  0,   0, 0,     4, 0, 0);
        add_vec(4, 2,   0,   0,   1,   1,   0,  3, 255, 1,   256, 2, 0);
        add_vec(2, 0, 255, 255,   0,   9,   0,  0,   0, 0, 65025, 1, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            for (int j = 0; j < 4; j++) begin
                pa[j] = vecs[i].a[j]; pb[j] = vecs[i].b[j];
            end
            run_op(vecs[i].len, vecs[i].mode, 1'b0);
            check_op($sformatf("vec%0d", i), vecs[i].len, vecs[i].exp_dot, vecs[i].exp_skip, vecs[i].exp_ovf);
        end

        // start while busy must not restart or shorten the running operation
        pa[0] = 3; pb[0] = 4; pa[1] = 5; pb[1] = 6; pa[2] = 7; pb[2] = 8;
        run_op(3, 0, 1'b1);
        check_op("busy_start", 3, 98, 0, 0);

        // len above MAX_LEN is clamped
        for (int j = 0; j < 30; j++) begin
            pa[j] = 1; pb[j] = 1;
        end
        run_op(30, 0, 1'b0);
        check_op("clamp", MAX_LEN, MAX_LEN, 0, 0);

        // reset after 2 of 5 handshakes
        @(negedge clk);
        start = 1'b1; len = 8'd5;
        @(negedge clk);
        start = 1'b0; hs = 0;
        for (int k = 0; k < 20 && hs < 2; k++) begin
            in_valid = 1'b1; in_a = 8'd50 + 8'(hs); in_b = 8'd7;
            if (in_ready) hs++;
            @(negedge clk);
        end
        check("mid_hs_count", hs, 2);
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset("mid_reset");
        @(negedge clk);
        check("stale_ignored dot", {16'd0, dot}, 0);
        check("stale_ignored skip", {24'd0, skip_count}, 0);
        pa[0] = 9; pb[0] = 0;
        run_op(1, 0, 1'b0);
        check_op("after_reset", 1, 0, 1, 0);

        // randomized operations against a sum/count model
        for (int t = 0; t < 25; t++) begin
            n_len = $urandom_range(0, 26);
            eff = (n_len > MAX_LEN) ? MAX_LEN : n_len;
            sum = 0; skips = 0;
            for (int j = 0; j < eff; j++) begin
                r = $urandom_range(0, 3);
                pa[j] = (r == 0) ? 8'd0 : (r == 1) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(0, 255));
                pb[j] = 8'($urandom_range(0, 40));
                sum += int'(pa[j]) * int'(pb[j]);
                if (pa[j] == 0 || pb[j] == 0) skips++;
            end
            run_op(n_len, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
            check_op($sformatf("rand%0d", t), eff, (sum > ACC_MAX) ? ACC_MAX : sum, skips,
                     (sum > ACC_MAX) ? 1 : 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
